// File: rtl/bayer_bin2x2_rgb.sv
// bayer_bin2x2_rgb: 2x2 Bayer binning to half-resolution RGB using a one-line buffer of even-row pairs
module bayer_bin2x2_rgb #(
    parameter int PIXEL_W  = 12,
    parameter int OUT_W    = 8,
    parameter int MAX_LINE = 1280
) (
    input  logic               piul1Clock,
    input  logic               piul1Reset,
    input  logic               piul1FrameValid,
    input  logic               piul1LineValid,
    input  logic               piul1PixelValid,
    input  logic [PIXEL_W-1:0] piulPixel,
    output logic               poul1RgbValid,
    output logic [OUT_W-1:0]   poulRed,
    output logic [OUT_W-1:0]   poulGreen,
    output logic [OUT_W-1:0]   poulBlue,
    output logic               poul1StartOfFrame,
    output logic               poul1LineDone,
    output logic               poul1Overflow
);
    localparam int COL_W  = $clog2(MAX_LINE + 1);
    localparam int ADDR_W = $clog2(MAX_LINE / 2);

    typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW} state_t;

    state_t                 state, state_next;
    logic                   fv_q, lv_q;
    logic [COL_W-1:0]       col;
    logic [PIXEL_W-1:0]     g1_hold, b_hold;
    logic [2*PIXEL_W-1:0]   line_buf [MAX_LINE/2];
    logic [2*PIXEL_W-1:0]   rd_data;
    logic                   sof_armed;
    logic                   fv_rise, fv_fall, lv_fall;
    logic                   accept, in_range, take;
    logic                   wr_en, rd_en, emit;
    logic [ADDR_W-1:0]      addr;
    logic [PIXEL_W:0]       green_sum;
    logic                   unused_bits;

    assign fv_rise   = piul1FrameValid & ~fv_q;
    assign fv_fall   = ~piul1FrameValid & fv_q;
    assign lv_fall   = lv_q & ~piul1LineValid;
    assign accept    = (state != IDLE) & piul1FrameValid & piul1LineValid & piul1PixelValid;
    assign in_range  = col < COL_W'(MAX_LINE);
    assign take      = accept & in_range;
    assign addr      = col[ADDR_W:1];
    assign wr_en     = take & (state == EVEN_ROW) & col[0];
    assign rd_en     = take & (state == ODD_ROW) & ~col[0];
    assign emit      = take & (state == ODD_ROW) & col[0];
    assign green_sum = {1'b0, rd_data[2*PIXEL_W-1:PIXEL_W]} + {1'b0, piulPixel};
    assign unused_bits = ^{green_sum, b_hold, rd_data};

    // Row-parity state machine: frame edges bracket the frame, non-empty line ends flip parity
    always_comb begin
        state_next = state;
        if (state == IDLE)
            state_next = fv_rise ? EVEN_ROW : IDLE;
        else if (fv_fall)
            state_next = IDLE;
        else if (lv_fall && col != '0)
            state_next = (state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
    end

    // Control, holding registers and registered RGB outputs; fv_q resets high so a frame already in flight at reset release is skipped
    always_ff @(posedge piul1Clock or posedge piul1Reset) begin
        if (piul1Reset) begin
            state             <= IDLE;
            fv_q              <= 1'b1;
            lv_q              <= 1'b0;
            col               <= '0;
            g1_hold           <= '0;
            b_hold            <= '0;
            sof_armed         <= 1'b0;
            poul1RgbValid     <= 1'b0;
            poulRed           <= '0;
            poulGreen         <= '0;
            poulBlue          <= '0;
            poul1StartOfFrame <= 1'b0;
            poul1LineDone     <= 1'b0;
            poul1Overflow     <= 1'b0;
        end else begin
            state             <= state_next;
            fv_q              <= piul1FrameValid;
            lv_q              <= piul1LineValid;
            poul1RgbValid     <= emit;
            poul1StartOfFrame <= emit & sof_armed;
            poul1LineDone     <= (state == ODD_ROW) & piul1FrameValid & lv_fall & (col != '0);
            if (state == IDLE && fv_rise) begin
                sof_armed     <= 1'b1;
                poul1Overflow <= 1'b0;
            end else if (emit)
                sof_armed <= 1'b0;
            if (accept && !in_range)
                poul1Overflow <= 1'b1;
            if (state == IDLE || lv_fall)
                col <= '0;
            else if (take)
                col <= col + 1'b1;
            if (take && !col[0] && state == EVEN_ROW)
                g1_hold <= piulPixel;
            if (take && !col[0] && state == ODD_ROW)
                b_hold <= piulPixel;
            if (emit) begin
                poulRed   <= rd_data[PIXEL_W-1 -: OUT_W];
                poulGreen <= green_sum[PIXEL_W -: OUT_W];
                poulBlue  <= b_hold[PIXEL_W-1 -: OUT_W];
            end
        end
    end

    // Line buffer of {G1, R} pairs with a one-cycle synchronous read
    always_ff @(posedge piul1Clock) begin
        if (wr_en)
            line_buf[addr] <= {g1_hold, piulPixel};
        if (rd_en)
            rd_data <= line_buf[addr];
    end
endmodule

// File: tb/tb_bayer_bin2x2_rgb.sv
// tb_bayer_bin2x2_rgb: randomized and directed frames checked against a quad-level reference model
module tb_bayer_bin2x2_rgb;
    localparam int PW = 12;
    localparam int OW = 12;
    localparam int ML = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          fv, lv, pv;
    logic [PW-1:0] pix_in;
    logic          rgb_valid, sof, line_done, ovf;
    logic [OW-1:0] red, green, blue;

    typedef struct {
        longint     t;
        int         r;
        int         g;
        int         b;
        int         s;
    } px_t;

    px_t exp_q[$];
    px_t obs_q[$];
    int  ld_count = 0;
    int  stray_sof = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  img [0:7][0:39];

    bayer_bin2x2_rgb #(.PIXEL_W(PW), .OUT_W(OW), .MAX_LINE(ML)) dut (
        .piul1Clock(clk),
        .piul1Reset(rst),
        .piul1FrameValid(fv),
        .piul1LineValid(lv),
        .piul1PixelValid(pv),
        .piulPixel(pix_in),
        .poul1RgbValid(rgb_valid),
        .poulRed(red),
        .poulGreen(green),
        .poulBlue(blue),
        .poul1StartOfFrame(sof),
        .poul1LineDone(line_done),
        .poul1Overflow(ovf)
    );

    always #5 clk = ~clk;

    // Observe registered outputs midway between rising edges
    always @(negedge clk) begin
        if (rgb_valid)
            obs_q.push_back('{longint'($time), int'(red), int'(green), int'(blue), int'(sof)});
        if (line_done)
            ld_count++;
        if (sof && !rgb_valid)
            stray_sof++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint observed, input longint expected);
        n_chk++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic set_row(input int r, input int a, input int b, input int c, input int d);
        img[r][0] = a;
        img[r][1] = b;
        img[r][2] = c;
        img[r][3] = d;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 40; c++)
                img[r][c] = int'($urandom_range(4095, 0));
    endtask

    // Drive one frame; raise=0 means FrameValid is already high and nothing is expected
    task automatic drive_frame(input int nrows, input int width, input int gmax,
                               input int drop_row, input int drop_col, input bit raise);
        bit first;
        int g1, g2, rr, bb, gap;
        first = 1'b1;
        @(negedge clk);
        fv = 1'b1; lv = 1'b0; pv = 1'b0;
        repeat (2) @(negedge clk);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < width; c++) begin
                gap = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
                repeat (gap) begin
                    @(negedge clk);
                    lv = 1'b1; pv = 1'b0;
                end
                @(negedge clk);
                lv = 1'b1; pv = 1'b1; pix_in = PW'(img[r][c]);
                if (raise && r % 2 == 1 && c % 2 == 1 && c < ML) begin
                    g1 = img[r-1][c-1];
                    rr = img[r-1][c];
                    bb = img[r][c-1];
                    g2 = img[r][c];
                    exp_q.push_back('{longint'($time) + 10, rr >> (PW - OW),
                                      ((g1 + g2) / 2) >> (PW - OW), bb >> (PW - OW), int'(first)});
                    first = 1'b0;
                end
                if (r == drop_row && c == drop_col) begin
                    @(negedge clk);
                    fv = 1'b0; lv = 1'b0; pv = 1'b0;
                    repeat (3) @(negedge clk);
                    return;
                end
            end
            @(negedge clk);
            lv = 1'b0; pv = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        fv = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_frame(input string tag, input int exp_ld);
        int n;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_time%0d", tag, i), obs_q[i].t, exp_q[i].t);
            chk($sformatf("%s_red%0d", tag, i), obs_q[i].r, exp_q[i].r);
            chk($sformatf("%s_green%0d", tag, i), obs_q[i].g, exp_q[i].g);
            chk($sformatf("%s_blue%0d", tag, i), obs_q[i].b, exp_q[i].b);
            chk($sformatf("%s_sof%0d", tag, i), obs_q[i].s, exp_q[i].s);
        end
        chk({tag, "_linedone"}, ld_count, exp_ld);
        chk({tag, "_stray_sof"}, stray_sof, 0);
        exp_q.delete();
        obs_q.delete();
        ld_count = 0;
        stray_sof = 0;
    endtask

    initial begin
        rst = 1'b1; fv = 1'b0; lv = 1'b0; pv = 1'b0; pix_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid", rgb_valid, 0);
        chk("reset_rgb", {red, green, blue}, 0);
        chk("reset_sof", sof, 0);
        chk("reset_linedone", line_done, 0);
        chk("reset_ovf", ovf, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        set_row(0, 100, 200, 300, 400);
        set_row(1, 500, 600, 700, 800);
        drive_frame(2, 4, 0, -1, -1, 1'b1);
        if (obs_q.size() == 2) begin
            chk("basic_red0", obs_q[0].r, 200);
            chk("basic_green0", obs_q[0].g, 350);
            chk("basic_blue0", obs_q[0].b, 500);
            chk("basic_red1", obs_q[1].r, 400);
            chk("basic_green1", obs_q[1].g, 550);
            chk("basic_blue1", obs_q[1].b, 700);
        end
        compare_frame("basic", 1);

        set_row(0, 4095, 4095, 1, 7);
        set_row(1, 9, 4094, 3, 2);
        drive_frame(2, 4, 0, -1, -1, 1'b1);
        if (obs_q.size() == 2) begin
            chk("trunc_green_hi", obs_q[0].g, 4094);
            chk("trunc_red_max", obs_q[0].r, 4095);
            chk("trunc_green_lo", obs_q[1].g, 1);
        end
        compare_frame("trunc", 1);

        fill_rand();
        drive_frame(8, 24, 5, -1, -1, 1'b1);
        compare_frame("random_gaps", 4);

        fill_rand();
        drive_frame(3, 5, 2, -1, -1, 1'b1);
        compare_frame("odd_width", 1);

        fill_rand();
        drive_frame(2, ML, 0, -1, -1, 1'b1);
        chk("full_line_ovf", ovf, 0);
        compare_frame("full_line", 1);

        fill_rand();
        drive_frame(2, ML + 4, 1, -1, -1, 1'b1);
        chk("overflow_set", ovf, 1);
        compare_frame("overflow", 1);
        repeat (4) @(negedge clk);
        chk("overflow_held_idle", ovf, 1);
        fill_rand();
        drive_frame(2, 4, 0, -1, -1, 1'b1);
        chk("overflow_cleared", ovf, 0);
        compare_frame("after_overflow", 1);

        fill_rand();
        drive_frame(2, 4, 0, 1, 2, 1'b1);
        compare_frame("drop_after_b", 0);
        fill_rand();
        drive_frame(2, 4, 0, 1, 0, 1'b1);
        compare_frame("drop_first_b", 0);
        fill_rand();
        drive_frame(2, 4, 1, -1, -1, 1'b1);
        compare_frame("after_drop", 1);

        fill_rand();
        @(negedge clk);
        fv = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            lv = 1'b1; pv = 1'b1; pix_in = PW'(img[0][c]);
        end
        @(negedge clk);
        lv = 1'b0; pv = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            lv = 1'b1; pv = 1'b1; pix_in = PW'(img[1][c]);
        end
        @(negedge clk);
        pv = 1'b0;
        rst = 1'b1;
        #1;
        chk("midreset_valid", rgb_valid, 0);
        chk("midreset_rgb", {red, green, blue}, 0);
        chk("midreset_sof", sof, 0);
        chk("midreset_ovf", ovf, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lv = 1'b0;
        obs_q.delete();
        exp_q.delete();
        ld_count = 0;
        stray_sof = 0;
        fill_rand();
        drive_frame(2, 4, 0, -1, -1, 1'b0);
        compare_frame("held_after_reset", 0);
        chk("held_after_reset_rgb", {red, green, blue}, 0);
        fill_rand();
        drive_frame(2, 8, 2, -1, -1, 1'b1);
        compare_frame("after_reset", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
